// File: rtl/top_wrapper_pkg.sv
// Shared sizes, timing constants and FSM state type for the serial-link
// systolic matrix multiplier.
package top_wrapper_pkg;

    localparam int AW   = 8;
    localparam int BW   = 8;
    localparam int ACCW = 32;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K    = 4;

    localparam int A_WORDS = ROWS * K;
    localparam int B_WORDS = K * COLS;
    localparam int C_WORDS = ROWS * COLS;

    // Cycles needed for the last skewed operand pair to reach PE[ROWS-1][COLS-1]
    localparam int COMPUTE_CYCLES = K + ROWS + COLS - 1;

    // Each output word is one sync slot followed by ACCW data slots
    localparam int SLOT_CYCLES    = 2;
    localparam int SLOTS_PER_WORD = ACCW + 1;
    localparam int SEND_CYCLES    = C_WORDS * SLOTS_PER_WORD * SLOT_CYCLES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/top_wrapper_systolic_pe.sv
// One processing element of the output-stationary systolic array: passes
// a right and b down through registers and accumulates their signed product.
module systolic_pe
    import top_wrapper_pkg::*;
#(
    parameter int AW   = top_wrapper_pkg::AW,
    parameter int BW   = top_wrapper_pkg::BW,
    parameter int ACCW = top_wrapper_pkg::ACCW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            en,
    input  logic [AW-1:0]   a_in,
    input  logic [BW-1:0]   b_in,
    output logic [AW-1:0]   a_out,
    output logic [BW-1:0]   b_out,
    output logic [ACCW-1:0] acc
);

    logic signed [AW+BW-1:0] product;
    logic [ACCW-1:0]         product_ext;

    // Full-precision signed product, sign-extended to the accumulator width
    always_comb begin
        product     = $signed(a_in) * $signed(b_in);
        product_ext = ACCW'(product);
    end

    // Operand pass-through and wrapping accumulate; clear zeroes the whole PE
    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + product_ext;
        end
    end

endmodule

// File: rtl/top_wrapper.sv
// Matrix multiplier with serial A/B input links and a serial C output link.
// Two receivers fill the operand buffers, a systolic array computes C and a
// slot-based transmitter serializes the result row-major.
module top_wrapper
    import top_wrapper_pkg::*;
#(
    parameter int AW   = top_wrapper_pkg::AW,
    parameter int BW   = top_wrapper_pkg::BW,
    parameter int ACCW = top_wrapper_pkg::ACCW,
    parameter int ROWS = top_wrapper_pkg::ROWS,
    parameter int COLS = top_wrapper_pkg::COLS,
    parameter int K    = top_wrapper_pkg::K
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic A_in_serial_data,
    input  logic A_in_serial_clk,
    input  logic A_in_frame_sync,
    input  logic B_in_serial_data,
    input  logic B_in_serial_clk,
    input  logic B_in_frame_sync,
    output logic done,
    output logic C_out_serial_data,
    output logic C_out_serial_clk,
    output logic C_out_frame_sync
);

    localparam int NUM_A        = ROWS * K;
    localparam int NUM_B        = K * COLS;
    localparam int NUM_C        = ROWS * COLS;
    localparam int COMPUTE_LAST = K + ROWS + COLS - 2;
    localparam int AWC_W        = $clog2(NUM_A + 1);
    localparam int AIDX_W       = $clog2(NUM_A);
    localparam int BWC_W        = $clog2(NUM_B + 1);
    localparam int BIDX_W       = $clog2(NUM_B);
    localparam int CIDX_W       = $clog2(NUM_C);
    localparam int ABIT_W       = $clog2(AW);
    localparam int BBIT_W       = $clog2(BW);
    localparam int CC_W         = $clog2(K + ROWS + COLS - 1);
    localparam int SLOT_W       = $clog2(ACCW + 1);
    localparam int BIT_W        = $clog2(ACCW);

    state_t state;
    state_t state_next;

    logic start_latched;
    logic clear_buffers;
    logic buffers_full;
    logic pe_clear;
    logic pe_en;

    // A receiver state
    logic [1:0]        a_data_sync;
    logic [1:0]        a_clk_sync;
    logic [1:0]        a_fs_sync;
    logic              a_clk_prev;
    logic              a_armed;
    logic [ABIT_W-1:0] a_bit_cnt;
    logic [AW-2:0]     a_shift;
    logic [AWC_W-1:0]  a_words;
    logic [AW-1:0]     a_buf [NUM_A];

    // B receiver state
    logic [1:0]        b_data_sync;
    logic [1:0]        b_clk_sync;
    logic [1:0]        b_fs_sync;
    logic              b_clk_prev;
    logic              b_armed;
    logic [BBIT_W-1:0] b_bit_cnt;
    logic [BW-2:0]     b_shift;
    logic [BWC_W-1:0]  b_words;
    logic [BW-1:0]     b_buf [NUM_B];

    // Compute and transmit sequencing
    logic [CC_W-1:0]   comp_cnt;
    logic              phase;
    logic [SLOT_W-1:0] send_slot;
    logic [CIDX_W-1:0] send_word;
    logic [ACCW-1:0]   cur_word;

    // Systolic array wiring
    logic [AW-1:0]   a_edge [ROWS];
    logic [BW-1:0]   b_edge [COLS];
    logic [AW-1:0]   a_pass [ROWS][COLS];
    logic [BW-1:0]   b_pass [ROWS][COLS];
    logic [ACCW-1:0] acc_mat [NUM_C];

    // A link: synchronize, detect strobe rises, assemble LSB-first words into the A buffer
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_data_sync <= '0;
            a_clk_sync  <= '0;
            a_fs_sync   <= '0;
            a_clk_prev  <= 1'b0;
            a_armed     <= 1'b0;
            a_bit_cnt   <= '0;
            a_shift     <= '0;
            a_words     <= '0;
            for (int w = 0; w < NUM_A; w++) a_buf[w] <= '0;
        end else begin
            a_data_sync <= {a_data_sync[0], A_in_serial_data};
            a_clk_sync  <= {a_clk_sync[0], A_in_serial_clk};
            a_fs_sync   <= {a_fs_sync[0], A_in_frame_sync};
            a_clk_prev  <= a_clk_sync[1];
            if (clear_buffers) begin
                a_armed   <= 1'b0;
                a_bit_cnt <= '0;
                a_words   <= '0;
                for (int w = 0; w < NUM_A; w++) a_buf[w] <= '0;
            end else if (a_clk_sync[1] && !a_clk_prev) begin
                if (a_fs_sync[1]) begin
                    a_armed   <= 1'b1;
                    a_bit_cnt <= '0;
                end else if (a_armed) begin
                    a_shift <= {a_data_sync[1], a_shift[AW-2:1]};
                    if (a_bit_cnt == ABIT_W'(AW - 1)) begin
                        a_armed <= 1'b0;
                        if (a_words < AWC_W'(NUM_A)) begin
                            a_buf[a_words[AIDX_W-1:0]] <= {a_data_sync[1], a_shift};
                            a_words <= a_words + 1'b1;
                        end
                    end else begin
                        a_bit_cnt <= a_bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // B link: identical protocol to A, filling the B buffer
    always_ff @(posedge clk) begin
        if (rst_n) begin
            b_data_sync <= '0;
            b_clk_sync  <= '0;
            b_fs_sync   <= '0;
            b_clk_prev  <= 1'b0;
            b_armed     <= 1'b0;
            b_bit_cnt   <= '0;
            b_shift     <= '0;
            b_words     <= '0;
            for (int w = 0; w < NUM_B; w++) b_buf[w] <= '0;
        end else begin
            b_data_sync <= {b_data_sync[0], B_in_serial_data};
            b_clk_sync  <= {b_clk_sync[0], B_in_serial_clk};
            b_fs_sync   <= {b_fs_sync[0], B_in_frame_sync};
            b_clk_prev  <= b_clk_sync[1];
            if (clear_buffers) begin
                b_armed   <= 1'b0;
                b_bit_cnt <= '0;
                b_words   <= '0;
                for (int w = 0; w < NUM_B; w++) b_buf[w] <= '0;
            end else if (b_clk_sync[1] && !b_clk_prev) begin
                if (b_fs_sync[1]) begin
                    b_armed   <= 1'b1;
                    b_bit_cnt <= '0;
                end else if (b_armed) begin
                    b_shift <= {b_data_sync[1], b_shift[BW-2:1]};
                    if (b_bit_cnt == BBIT_W'(BW - 1)) begin
                        b_armed <= 1'b0;
                        if (b_words < BWC_W'(NUM_B)) begin
                            b_buf[b_words[BIDX_W-1:0]] <= {b_data_sync[1], b_shift};
                            b_words <= b_words + 1'b1;
                        end
                    end else begin
                        b_bit_cnt <= b_bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state decode and array control
    always_comb begin
        state_next    = state;
        buffers_full  = (a_words == AWC_W'(NUM_A)) && (b_words == BWC_W'(NUM_B));
        clear_buffers = (state == ST_DONE) && start;
        pe_clear      = (state == ST_IDLE) || (state == ST_LOAD);
        pe_en         = (state == ST_COMPUTE);
        case (state)
            ST_IDLE:    state_next = ST_LOAD;
            ST_LOAD:    if (buffers_full && start_latched) state_next = ST_COMPUTE;
            ST_COMPUTE: if (comp_cnt == CC_W'(COMPUTE_LAST)) state_next = ST_SEND;
            ST_SEND:    if (phase && (send_slot == SLOT_W'(ACCW)) &&
                            (send_word == CIDX_W'(NUM_C - 1))) state_next = ST_DONE;
            ST_DONE:    if (start) state_next = ST_LOAD;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Start request latch: armed in IDLE/LOAD or by a restart from DONE, consumed on COMPUTE entry
    always_ff @(posedge clk) begin
        if (rst_n) begin
            start_latched <= 1'b0;
        end else if ((state == ST_DONE) && start) begin
            start_latched <= 1'b1;
        end else if ((state == ST_LOAD) && (state_next == ST_COMPUTE)) begin
            start_latched <= 1'b0;
        end else if (start && ((state == ST_IDLE) || (state == ST_LOAD))) begin
            start_latched <= 1'b1;
        end
    end

    // Compute cycle counter and transmit slot/phase/word counters
    always_ff @(posedge clk) begin
        if (rst_n) begin
            comp_cnt  <= '0;
            phase     <= 1'b0;
            send_slot <= '0;
            send_word <= '0;
        end else begin
            if (state == ST_COMPUTE) begin
                comp_cnt <= comp_cnt + 1'b1;
            end else begin
                comp_cnt <= '0;
            end
            if (state == ST_SEND) begin
                phase <= ~phase;
                if (phase) begin
                    if (send_slot == SLOT_W'(ACCW)) begin
                        send_slot <= '0;
                        send_word <= send_word + 1'b1;
                    end else begin
                        send_slot <= send_slot + 1'b1;
                    end
                end
            end else begin
                phase     <= 1'b0;
                send_slot <= '0;
                send_word <= '0;
            end
        end
    end

    // Skewed edge feed: row i sees A[i][k] and column j sees B[k][j] at cycle i+k / j+k, else zero
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            a_edge[i] = '0;
            for (int k = 0; k < K; k++) begin
                if ((state == ST_COMPUTE) && (comp_cnt == CC_W'(i + k))) a_edge[i] = a_buf[i*K + k];
            end
        end
        for (int j = 0; j < COLS; j++) begin
            b_edge[j] = '0;
            for (int k = 0; k < K; k++) begin
                if ((state == ST_COMPUTE) && (comp_cnt == CC_W'(j + k))) b_edge[j] = b_buf[k*COLS + j];
            end
        end
    end

    genvar gi, gj;
    for (gi = 0; gi < ROWS; gi++) begin : g_row
        for (gj = 0; gj < COLS; gj++) begin : g_col
            logic [AW-1:0] a_left;
            logic [BW-1:0] b_top;
            if (gj == 0) begin : g_a_edge
                assign a_left = a_edge[gi];
            end else begin : g_a_chain
                assign a_left = a_pass[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_top = b_edge[gj];
            end else begin : g_b_chain
                assign b_top = b_pass[gi-1][gj];
            end
            systolic_pe #(
                .AW   (AW),
                .BW   (BW),
                .ACCW (ACCW)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (pe_clear),
                .en    (pe_en),
                .a_in  (a_left),
                .b_in  (b_top),
                .a_out (a_pass[gi][gj]),
                .b_out (b_pass[gi][gj]),
                .acc   (acc_mat[gi*COLS + gj])
            );
        end
    end

    // Output link: slot 0 is the sync slot, slots 1..ACCW carry the word LSB first; idle low outside SEND
    always_comb begin
        cur_word          = acc_mat[send_word];
        done              = (state == ST_DONE);
        C_out_serial_clk  = 1'b0;
        C_out_frame_sync  = 1'b0;
        C_out_serial_data = 1'b0;
        if (state == ST_SEND) begin
            C_out_serial_clk = phase;
            if (send_slot == '0) begin
                C_out_frame_sync = 1'b1;
            end else begin
                C_out_serial_data = cur_word[BIT_W'(send_slot - 1'b1)];
            end
        end
    end

endmodule

// File: tb/tb_top_wrapper.sv
// Directed self-checking bench for top_wrapper: loads A/B over the serial
// links, deserializes C and compares against hand-computed products.
module tb_top_wrapper;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic A_in_serial_data, A_in_serial_clk, A_in_frame_sync;
    logic B_in_serial_data, B_in_serial_clk, B_in_frame_sync;
    logic done;
    logic C_out_serial_data, C_out_serial_clk, C_out_frame_sync;

    int checkCount = 0;
    int passCount  = 0;

    int caseA [16];
    int caseB [16];
    int caseC [16];
    logic [31:0] rxC [16];
    int rxWords;
    int rxCycles;

    top_wrapper dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .A_in_serial_data  (A_in_serial_data),
        .A_in_serial_clk   (A_in_serial_clk),
        .A_in_frame_sync   (A_in_frame_sync),
        .B_in_serial_data  (B_in_serial_data),
        .B_in_serial_clk   (B_in_serial_clk),
        .B_in_frame_sync   (B_in_frame_sync),
        .done              (done),
        .C_out_serial_data (C_out_serial_data),
        .C_out_serial_clk  (C_out_serial_clk),
        .C_out_frame_sync  (C_out_frame_sync)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One serial slot: data/sync set with strobe low for 2 cycles, then strobe high for 2 cycles
    task automatic serialBit(input bit toB, input bit fs, input bit d);
        if (toB) begin
            B_in_serial_data = d;
            B_in_frame_sync  = fs;
            B_in_serial_clk  = 1'b0;
        end else begin
            A_in_serial_data = d;
            A_in_frame_sync  = fs;
            A_in_serial_clk  = 1'b0;
        end
        tick();
        tick();
        if (toB) B_in_serial_clk = 1'b1;
        else     A_in_serial_clk = 1'b1;
        tick();
        tick();
    endtask

    task automatic sendWord(input bit toB, input logic [7:0] w);
        serialBit(toB, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) serialBit(toB, 1'b0, w[i]);
    endtask

    task automatic applyStimulus(input bit partialFirst);
        for (int w = 0; w < 16; w++) begin
            if (partialFirst && w == 0) begin
                serialBit(1'b0, 1'b1, 1'b0);
                serialBit(1'b0, 1'b0, 1'b1);
                serialBit(1'b0, 1'b0, 1'b1);
                serialBit(1'b0, 1'b0, 1'b1);
            end
            sendWord(1'b0, 8'(caseA[w]));
        end
        for (int w = 0; w < 16; w++) sendWord(1'b1, 8'(caseB[w]));
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Deserialize C until done (bounded); optionally pulse start at cycle startAt
    task automatic collectC(input int startAt);
        int cyc;
        int firstSend;
        int bitIdx;
        logic prevClk;
        logic inWord;
        logic [31:0] shiftReg;
        cyc = 0;
        firstSend = -1;
        bitIdx = 0;
        prevClk = 1'b0;
        inWord = 1'b0;
        shiftReg = '0;
        rxWords = 0;
        rxCycles = -1;
        for (int i = 0; i < 16; i++) rxC[i] = 32'hDEADBEEF;
        while (cyc < 3000 && done !== 1'b1) begin
            tick();
            cyc++;
            start = (cyc == startAt);
            if (C_out_frame_sync === 1'b1 && firstSend < 0) firstSend = cyc;
            if (C_out_serial_clk === 1'b1 && prevClk === 1'b0) begin
                if (C_out_frame_sync === 1'b1) begin
                    inWord = 1'b1;
                    bitIdx = 0;
                end else if (inWord) begin
                    shiftReg[bitIdx] = C_out_serial_data;
                    bitIdx++;
                    if (bitIdx == 32) begin
                        if (rxWords < 16) rxC[rxWords] = shiftReg;
                        rxWords++;
                        inWord = 1'b0;
                    end
                end
            end
            prevClk = C_out_serial_clk;
        end
        start = 1'b0;
        if (done === 1'b1 && firstSend >= 0) rxCycles = cyc - firstSend;
    endtask

    task automatic checkResult(input string name);
        checkOutput({name, " done"}, 32'(done), 32'd1);
        checkOutput({name, " words"}, rxWords, 32'd16);
        checkOutput({name, " send_cycles"}, rxCycles, 32'd1056);
        for (int i = 0; i < 16; i++)
            checkOutput($sformatf("%s C[%0d][%0d]", name, i / 4, i % 4), rxC[i], caseC[i]);
    endtask

    task automatic setSpecCase();
        caseA = '{1, 2, 3, 4,  0, -1, 2, 3,  2, 2, -1, 1,  4, 0, 1, -2};
        caseB = '{1, 0, -1, 2,  2, 1, 0, 0,  -1, 2, 1, 1,  3, -1, 2, 0};
        caseC = '{14, 4, 10, 5,  5, 0, 8, 2,  10, -1, -1, 3,  -3, 4, -7, 9};
    endtask

    task automatic setUniformCase(input int a, input int b, input int c);
        for (int i = 0; i < 16; i++) begin
            caseA[i] = a;
            caseB[i] = b;
            caseC[i] = c;
        end
    endtask

    initial begin
        int fsCount;
        logic prevFs;
        logic found;

        rst_n = 1'b1;
        start = 1'b0;
        A_in_serial_data = 1'b0; A_in_serial_clk = 1'b0; A_in_frame_sync = 1'b0;
        B_in_serial_data = 1'b0; B_in_serial_clk = 1'b0; B_in_frame_sync = 1'b0;
        repeat (3) tick();
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset c_out", 32'({C_out_serial_clk, C_out_frame_sync, C_out_serial_data}), 32'd0);
        rst_n = 1'b0;
        tick();

        $display("[TB] T1 reference matrices, start before load");
        pulseStart();
        setSpecCase();
        applyStimulus(1'b0);
        collectC(-1);
        checkResult("T1");
        repeat (5) tick();
        checkOutput("T1 done_hold", 32'(done), 32'd1);
        checkOutput("T1 idle c_out", 32'({C_out_serial_clk, C_out_frame_sync, C_out_serial_data}), 32'd0);

        $display("[TB] T2 all -128 x -128");
        pulseStart();
        checkOutput("T2 done_cleared", 32'(done), 32'd0);
        setUniformCase(-128, -128, 65536);
        applyStimulus(1'b0);
        collectC(-1);
        checkResult("T2");

        $display("[TB] T3 all 127 x -128");
        pulseStart();
        setUniformCase(127, -128, -65024);
        applyStimulus(1'b0);
        collectC(-1);
        checkResult("T3");

        $display("[TB] T4 aborted partial A word");
        pulseStart();
        setSpecCase();
        applyStimulus(1'b1);
        collectC(-1);
        checkResult("T4");

        $display("[TB] T5 reset during transmission");
        pulseStart();
        setUniformCase(127, -128, -65024);
        applyStimulus(1'b0);
        fsCount = 0;
        prevFs = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            tick();
            if (C_out_frame_sync === 1'b1 && prevFs === 1'b0) begin
                fsCount++;
                if (fsCount == 2) found = 1'b1;
            end
            prevFs = C_out_frame_sync;
        end
        checkOutput("T5 second_sync_seen", 32'(found), 32'd1);
        rst_n = 1'b1;
        tick();
        checkOutput("T5 reset done", 32'(done), 32'd0);
        checkOutput("T5 reset serial_clk", 32'(C_out_serial_clk), 32'd0);
        checkOutput("T5 reset frame_sync", 32'(C_out_frame_sync), 32'd0);
        checkOutput("T5 reset serial_data", 32'(C_out_serial_data), 32'd0);
        rst_n = 1'b0;
        tick();

        $display("[TB] T6 reload after reset, start ignored during transmission");
        pulseStart();
        setSpecCase();
        applyStimulus(1'b0);
        collectC(300);
        checkResult("T6");
        repeat (10) tick();
        checkOutput("T6 done_hold", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/top_wrapper.md
TOP_WRAPPER -- requirements
Module: top_wrapper

Interface
REQ-001 Parameters (name, default, meaning): AW 8 A element width; BW 8 B element width; ACCW 32 accumulator/result width; ROWS 4 array rows; COLS 4 array columns; K 4 inner dimension.
REQ-002 clk  input  1  sole clock; all logic on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-high (1 = reset).
REQ-004 start  input  1  one-cycle pulse requesting a matrix multiply.
REQ-005 A_in_serial_data / A_in_serial_clk / A_in_frame_sync  input  1 each  A serial link: data, bit strobe, word sync.
REQ-006 B_in_serial_data / B_in_serial_clk / B_in_frame_sync  input  1 each  B serial link, same protocol as A.
REQ-007 done  output  1  high when C has been fully transmitted.
REQ-008 C_out_serial_data / C_out_serial_clk / C_out_frame_sync  output  1 each  C serial link.

Function
REQ-009 Serial inputs SHALL be treated as data in the clk domain: each passes a 2-flop synchronizer; a bit event is a 0->1 transition of the synchronized serial_clk.
REQ-010 At a bit event with frame_sync=1 the receiver SHALL arm, clearing its bit counter and discarding any partial word.
REQ-011 While armed, each bit event with frame_sync=0 SHALL capture serial_data LSB first; after AW (BW) bits the word is complete and the receiver disarms.
REQ-012 Completed A words SHALL fill A[r][k] row-major (16 words); completed B words SHALL fill B[k][c] row-major (16 words); words beyond 16 are dropped until the next run.
REQ-013 Loading SHALL proceed independently of start; a start pulse in IDLE/LOAD SHALL be latched; start in COMPUTE/SEND SHALL be ignored.
REQ-014 FSM states: IDLE -> LOAD on reset release; LOAD -> COMPUTE when both buffers hold 16 words and start is latched; COMPUTE -> SEND after exactly K+ROWS+COLS-1 = 11 cycles; SEND -> DONE after last output bit slot; DONE -> LOAD on start (buffers and counters cleared, start latched).
REQ-015 COMPUTE SHALL use a ROWS x COLS output-stationary systolic array: A row i enters left edge skewed by i cycles, B column j enters top edge skewed by j cycles, zeros outside valid data.
REQ-016 Each PE SHALL compute acc += sext(a)*sext(b): signed AWxBW product sign-extended to ACCW, two's-complement wrap on overflow; accumulators cleared on COMPUTE entry.
REQ-017 Result C[i][j] = sum over k of A[i][k]*B[k][j], ACCW bits signed.
REQ-018 SEND SHALL transmit 16 words row-major C[0][0]..C[3][3]; each word = 1 sync slot (frame_sync=1, data=0) then ACCW data slots LSB first (frame_sync=0); words back-to-back.
REQ-019 Each slot SHALL last 2 clk cycles: C_out_serial_clk=0 in the first, 1 in the second; data/frame_sync change only at slot start; per run 16*33 slots = 1056 cycles.
REQ-020 Outside SEND, C_out_serial_clk, C_out_serial_data, C_out_frame_sync SHALL be 0.
REQ-021 done SHALL rise the cycle after the final slot and hold until the next accepted start or reset.

Reset
REQ-022 rst_n=1 at a clk edge SHALL clear FSM to IDLE, both buffers, receivers, accumulators, latched start, and drive done and all C_out_* to 0, including mid-load, mid-compute, mid-send.
REQ-023 The first cycle after reset release SHALL enter LOAD with empty buffers.

Structure
REQ-024 A shared package SHALL hold AW, BW, ACCW, ROWS, COLS, K, the FSM state enum and slot/cycle constants.
REQ-025 One sub-module systolic_pe (registered a/b pass-through right/down plus MAC accumulator) SHALL be instantiated ROWS x COLS; receivers, buffers, FSM and transmitter stay in top_wrapper.

Verification
REQ-026 A=[[1,2,3,4],[0,-1,2,3],[2,2,-1,1],[4,0,1,-2]], B=[[1,0,-1,2],[2,1,0,0],[-1,2,1,1],[3,-1,2,0]], start -> C=[[14,4,10,5],[5,0,8,2],[10,-1,-1,3],[-3,4,-7,9]] deserialized, then done=1.
REQ-027 All A=-128, all B=-128 -> every C = 65536; A=127, B=-128 -> every C = -65024.
REQ-028 Frame_sync re-asserted after 3 bits of an A word -> partial discarded; next 8 bits load as that word; result still correct.
REQ-029 start before buffers full -> COMPUTE begins exactly when the 16th word completes; start during SEND ignored, single 1056-cycle transmission.
REQ-030 rst_n=1 mid-SEND -> next cycle done=0, all C_out_*=0; fresh load+start yields correct C.
